// File: rtl/cnt_scan_checker.sv
// Round-robin golden-vs-DUT counter compare with saturating error count and first-failure capture.
// Latency: 2 cycles per channel, done after 2*NUM_CH*PASSES cycles from the start edge.
// Backpressure: none; start is ignored while busy, inputs are sampled only in CAPTURE.
module cnt_scan_checker #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int PASSES = 200,
    parameter int ERR_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      design_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CH*CNT_W-1:0]   cnt_gold,
    input  logic [NUM_CH*CNT_W-1:0]   cnt_dut,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          mismatch_cnt,
    output logic                      first_err_valid,
    output logic [CH_W-1:0]           first_err_ch,
    output logic [CNT_W-1:0]          first_err_gold,
    output logic [CNT_W-1:0]          first_err_dut,
    output logic [CH_W-1:0]           cur_ch
);

    localparam int PC_W = $clog2(PASSES + 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] gold;
        logic [CNT_W-1:0] dut;
    } err_rec_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pass_cnt;
    logic [CNT_W-1:0] sample_gold;
    logic [CNT_W-1:0] sample_dut;
    logic [CNT_W-1:0] gold_sel;
    logic [CNT_W-1:0] dut_sel;
    err_rec_t         first_err;
    logic             run_go;
    logic             miscmp;
    logic             last_ch;
    logic             last_pass;

    assign run_go    = start && ((state == IDLE) || (state == DONE));
    assign miscmp    = (sample_gold != sample_dut);
    assign last_ch   = (cur_ch == LAST_CH);
    assign last_pass = ((pass_cnt + 1'b1) == LAST_PASS);

    assign first_err_ch   = first_err.ch;
    assign first_err_gold = first_err.gold;
    assign first_err_dut  = first_err.dut;

    // Channel select feeding the single registered capture stage.
    always_comb begin
        gold_sel = '0;
        dut_sel  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch == CH_W'(k)) begin
                gold_sel = cnt_gold[k*CNT_W +: CNT_W];
                dut_sel  = cnt_dut[k*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge design_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = COMPARE;
            end
            COMPARE: begin
                busy = 1'b1;
                if (last_ch && last_pass) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = CAPTURE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge design_clk or posedge reset) begin
        if (reset) begin
            cur_ch          <= '0;
            pass_cnt        <= '0;
            sample_gold     <= '0;
            sample_dut      <= '0;
            mismatch_cnt    <= '0;
            first_err_valid <= 1'b0;
            first_err       <= '0;
            pass            <= 1'b0;
        end else if (run_go) begin
            cur_ch          <= '0;
            pass_cnt        <= '0;
            mismatch_cnt    <= '0;
            first_err_valid <= 1'b0;
            first_err       <= '0;
            pass            <= 1'b0;
        end else if (state == CAPTURE) begin
            sample_gold <= gold_sel;
            sample_dut  <= dut_sel;
        end else if (state == COMPARE) begin
            if (miscmp) begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err       <= '{ch: cur_ch, gold: sample_gold, dut: sample_dut};
                end
            end
            if (last_ch) begin
                cur_ch   <= '0;
                pass_cnt <= pass_cnt + 1'b1;
                // Verdict must include the compare happening on this same edge.
                if (last_pass) begin
                    pass <= (mismatch_cnt == '0) && !miscmp;
                end
            end else begin
                cur_ch <= cur_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnt_scan_checker.sv
// Randomized self-checking bench: small (4ch/3 passes), saturating (ERR_W=2) and default instances
// checked against a pass/channel loop model of the scan.
module tb_cnt_scan_checker;

    localparam int NA = 4;
    localparam int PA = 3;
    localparam int RUN_A = 2 * NA * PA;
    localparam int ND = 16;
    localparam int PD = 200;
    localparam int RUN_D = 2 * ND * PD;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] gold_v, dut_v, gold_t, dut_t;

    logic        a_busy, a_done, a_pass, a_fev;
    logic [15:0] a_mm;
    logic [1:0]  a_fch, a_cur;
    logic [7:0]  a_fg, a_fd;

    logic        s_busy, s_done, s_pass, s_fev;
    logic [1:0]  s_mm;
    logic [1:0]  s_fch, s_cur;
    logic [7:0]  s_fg, s_fd;

    logic         d_start;
    logic [127:0] d_gold, d_dut;
    logic         d_busy, d_done, d_pass, d_fev;
    logic [15:0]  d_mm;
    logic [3:0]   d_fch, d_cur;
    logic [7:0]   d_fg, d_fd;

    int n_cmp = 0;
    int n_bad = 0;

    cnt_scan_checker #(.NUM_CH(NA), .CNT_W(8), .PASSES(PA), .ERR_W(16)) u_a (
        .design_clk(clk), .reset(reset), .start(start), .cnt_gold(gold_v), .cnt_dut(dut_v),
        .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch_cnt(a_mm),
        .first_err_valid(a_fev), .first_err_ch(a_fch), .first_err_gold(a_fg),
        .first_err_dut(a_fd), .cur_ch(a_cur));

    cnt_scan_checker #(.NUM_CH(NA), .CNT_W(8), .PASSES(PA), .ERR_W(2)) u_s (
        .design_clk(clk), .reset(reset), .start(start), .cnt_gold(gold_v), .cnt_dut(dut_v),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_cnt(s_mm),
        .first_err_valid(s_fev), .first_err_ch(s_fch), .first_err_gold(s_fg),
        .first_err_dut(s_fd), .cur_ch(s_cur));

    cnt_scan_checker u_d (
        .design_clk(clk), .reset(reset), .start(d_start), .cnt_gold(d_gold), .cnt_dut(d_dut),
        .busy(d_busy), .done(d_done), .pass(d_pass), .mismatch_cnt(d_mm),
        .first_err_valid(d_fev), .first_err_ch(d_fch), .first_err_gold(d_fg),
        .first_err_dut(d_fd), .cur_ch(d_cur));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every pass sees the same constant vectors, so the expected result is a plain count over passes x channels.
    function automatic void model_small(input logic [31:0] g, input logic [31:0] d, input int errw,
                                        output int mm, output bit fev, output int fch,
                                        output logic [7:0] fg, output logic [7:0] fd);
        int raw;
        int cap;
        raw = 0; fev = 0; fch = 0; fg = 8'h0; fd = 8'h0;
        for (int p = 0; p < PA; p++) begin
            for (int c = 0; c < NA; c++) begin
                if (g[c*8 +: 8] != d[c*8 +: 8]) begin
                    raw++;
                    if (!fev) begin
                        fev = 1; fch = c; fg = g[c*8 +: 8]; fd = d[c*8 +: 8];
                    end
                end
            end
        end
        cap = (1 << errw) - 1;
        mm = (raw > cap) ? cap : raw;
    endfunction

    function automatic logic [7:0] bank_gold(input int base, input int p, input int c);
        return 8'(base + p * 3 + c * 17);
    endfunction

    function automatic logic [7:0] bank_dut(input int base, input int p, input int c);
        if (c == 15 && p >= 100) return 8'(bank_gold(base, p, c) + 8'd1 + 8'(p));
        return bank_gold(base, p, c);
    endfunction

    // Pulses start, then counts edges after the start edge until done; optionally scrambles inputs in COMPARE.
    task automatic run_a(input bit glitch, input int restart_at, output int edges, output bit busy0);
        @(posedge clk); #1;
        gold_v = gold_t; dut_v = dut_t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; edges = 0; busy0 = a_busy;
        while (!a_done && edges < 4 * RUN_A) begin
            @(posedge clk); edges++; #1;
            start = (edges == restart_at);
            if (glitch && (edges % 2 == 1)) begin
                gold_v = $urandom; dut_v = $urandom;
            end else begin
                gold_v = gold_t; dut_v = dut_t;
            end
        end
        start = 1'b0; gold_v = gold_t; dut_v = dut_t;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; d_start = 1'b0;
        gold_v = '0; dut_v = '0; gold_t = '0; dut_t = '0; d_gold = '0; d_dut = '0;
        #3;
        if ({a_busy, a_done, a_pass, a_mm, a_fev, a_fch, a_fg, a_fd, a_cur} !== '0) begin
            n_bad++; $display("FAIL reset_a: outputs %h, want 0", {a_busy, a_done, a_pass, a_mm, a_fev, a_fch, a_fg, a_fd, a_cur});
        end
        n_cmp++;
        if ({s_busy, s_done, s_pass, s_mm, s_fev, s_fch, s_fg, s_fd, s_cur} !== '0) begin
            n_bad++; $display("FAIL reset_s: outputs %h, want 0", {s_busy, s_done, s_pass, s_mm, s_fev, s_fch, s_fg, s_fd, s_cur});
        end
        n_cmp++;
        if ({d_busy, d_done, d_pass, d_mm, d_fev, d_fch, d_fg, d_fd, d_cur} !== '0) begin
            n_bad++; $display("FAIL reset_d: outputs %h, want 0", {d_busy, d_done, d_pass, d_mm, d_fev, d_fch, d_fg, d_fd, d_cur});
        end
        n_cmp++;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if ({a_busy, a_done} !== 2'b00) begin
            n_bad++; $display("FAIL idle_after_reset: busy/done %b, want 00", {a_busy, a_done});
        end
        n_cmp++;
    endtask

    task automatic test_all_match();
        int edges; bit b0;
        gold_t = {4{8'h5A}}; dut_t = {4{8'h5A}};
        run_a(1'b0, -1, edges, b0);
        if (b0 !== 1'b1) begin n_bad++; $display("FAIL match_busy_rise: got %b want 1", b0); end
        n_cmp++;
        if (edges !== RUN_A) begin n_bad++; $display("FAIL match_len: got %0d want %0d", edges, RUN_A); end
        n_cmp++;
        if ({a_pass, a_busy, a_fev} !== 3'b100) begin
            n_bad++; $display("FAIL match_flags: pass/busy/fev %b want 100", {a_pass, a_busy, a_fev});
        end
        n_cmp++;
        if (a_mm !== 16'd0) begin n_bad++; $display("FAIL match_mm: got %0d want 0", a_mm); end
        n_cmp++;
    endtask

    task automatic test_single_ch();
        int edges; bit b0;
        gold_t = {8'h77, 8'h10, 8'h33, 8'h44}; dut_t = {8'h77, 8'h11, 8'h33, 8'h44};
        run_a(1'b0, -1, edges, b0);
        if (edges !== RUN_A) begin n_bad++; $display("FAIL ch2_len: got %0d want %0d", edges, RUN_A); end
        n_cmp++;
        if (a_pass !== 1'b0) begin n_bad++; $display("FAIL ch2_pass: got %b want 0", a_pass); end
        n_cmp++;
        if (a_mm !== 16'd3) begin n_bad++; $display("FAIL ch2_mm: got %0d want 3", a_mm); end
        n_cmp++;
        if ({a_fev, a_fch, a_fg, a_fd} !== {1'b1, 2'd2, 8'h10, 8'h11}) begin
            n_bad++; $display("FAIL ch2_first: got %h want %h", {a_fev, a_fch, a_fg, a_fd}, {1'b1, 2'd2, 8'h10, 8'h11});
        end
        n_cmp++;
    endtask

    task automatic test_saturate();
        int edges; bit b0;
        gold_t = $urandom; dut_t = gold_t ^ 32'h0102_0408;
        run_a(1'b0, -1, edges, b0);
        if (s_mm !== 2'd3) begin n_bad++; $display("FAIL sat_mm: got %0d want 3", s_mm); end
        n_cmp++;
        if (a_mm !== 16'd12) begin n_bad++; $display("FAIL sat_unsat_mm: got %0d want 12", a_mm); end
        n_cmp++;
        if ({s_fev, s_fch, s_fg, s_fd} !== {1'b1, 2'd0, gold_t[7:0], dut_t[7:0]}) begin
            n_bad++; $display("FAIL sat_first: got %h want %h", {s_fev, s_fch, s_fg, s_fd}, {1'b1, 2'd0, gold_t[7:0], dut_t[7:0]});
        end
        n_cmp++;
        if ({s_done, s_pass} !== 2'b10) begin n_bad++; $display("FAIL sat_done: done/pass %b want 10", {s_done, s_pass}); end
        n_cmp++;
    endtask

    task automatic test_random();
        int edges, emm, efch, smm, sfch; bit b0, efev, sfev;
        logic [7:0] efg, efd, sfg, sfd;
        for (int it = 0; it < 8; it++) begin
            gold_t = $urandom; dut_t = gold_t;
            for (int c = 0; c < NA; c++) begin
                if ($urandom_range(0, 2) == 0) dut_t[c*8 +: 8] = gold_t[c*8 +: 8] ^ 8'($urandom_range(1, 255));
            end
            model_small(gold_t, dut_t, 16, emm, efev, efch, efg, efd);
            model_small(gold_t, dut_t, 2, smm, sfev, sfch, sfg, sfd);
            run_a(it[0], -1, edges, b0);
            if (edges !== RUN_A) begin n_bad++; $display("FAIL rnd%0d_len: got %0d want %0d", it, edges, RUN_A); end
            n_cmp++;
            if (a_pass !== (emm == 0)) begin n_bad++; $display("FAIL rnd%0d_pass: got %b want %b", it, a_pass, emm == 0); end
            n_cmp++;
            if (a_mm !== 16'(emm)) begin n_bad++; $display("FAIL rnd%0d_mm: got %0d want %0d", it, a_mm, emm); end
            n_cmp++;
            if ({a_fev, a_fch, a_fg, a_fd} !== {efev, 2'(efch), efg, efd}) begin
                n_bad++; $display("FAIL rnd%0d_first: got %h want %h", it, {a_fev, a_fch, a_fg, a_fd}, {efev, 2'(efch), efg, efd});
            end
            n_cmp++;
            if ({s_mm, s_pass} !== {2'(smm), smm == 0}) begin
                n_bad++; $display("FAIL rnd%0d_sat: got %h want %h", it, {s_mm, s_pass}, {2'(smm), smm == 0});
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_midrun();
        int edges; bit b0;
        gold_t = {8'h01, 8'h10, 8'h02, 8'h03}; dut_t = {8'h01, 8'h11, 8'h02, 8'h03};
        gold_v = gold_t; dut_v = dut_t;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (a_mm !== 16'd1) begin n_bad++; $display("FAIL midrun_mm: got %0d want 1", a_mm); end
        n_cmp++;
        reset = 1'b1;
        #1;
        if ({a_busy, a_done, a_mm, a_fev} !== '0) begin
            n_bad++; $display("FAIL midrun_reset: busy/done/mm/fev %h want 0", {a_busy, a_done, a_mm, a_fev});
        end
        n_cmp++;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if ({a_busy, a_done, a_mm} !== '0) begin
            n_bad++; $display("FAIL midrun_idle: busy/done/mm %h want 0", {a_busy, a_done, a_mm});
        end
        n_cmp++;
        run_a(1'b0, -1, edges, b0);
        if ({edges == RUN_A, a_mm} !== {1'b1, 16'd3}) begin
            n_bad++; $display("FAIL midrun_rerun: len %0d mm %0d want %0d/3", edges, a_mm, RUN_A);
        end
        n_cmp++;
    endtask

    task automatic test_start_ignored();
        int edges, emm, efch; bit b0, efev;
        logic [7:0] efg, efd;
        gold_t = $urandom; dut_t = gold_t ^ 32'h0000_2200;
        model_small(gold_t, dut_t, 16, emm, efev, efch, efg, efd);
        run_a(1'b0, 5, edges, b0);
        if (edges !== RUN_A) begin n_bad++; $display("FAIL busy_start_len: got %0d want %0d", edges, RUN_A); end
        n_cmp++;
        if ({a_mm, a_fch} !== {16'(emm), 2'(efch)}) begin
            n_bad++; $display("FAIL busy_start_stats: mm %0d ch %0d want %0d/%0d", a_mm, a_fch, emm, efch);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int edges;
        gold_t = $urandom; dut_t = gold_t ^ 32'h5500_0000;
        gold_v = gold_t; dut_v = dut_t;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 edges = 0;
        while (!a_done && edges < 4 * RUN_A) begin
            @(posedge clk); edges++; #1;
        end
        if ({edges == RUN_A, a_mm} !== {1'b1, 16'd3}) begin
            n_bad++; $display("FAIL b2b_first: len %0d mm %0d want %0d/3", edges, a_mm, RUN_A);
        end
        n_cmp++;
        @(posedge clk); #1;
        if ({a_done, a_busy, a_pass, a_mm, a_fev} !== {1'b0, 1'b1, 1'b0, 16'd0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_clear: done/busy/pass/mm/fev %h want %h", {a_done, a_busy, a_pass, a_mm, a_fev}, {1'b0, 1'b1, 1'b0, 16'd0, 1'b0});
        end
        n_cmp++;
        edges = 0;
        while (!a_done && edges < 4 * RUN_A) begin
            @(posedge clk); edges++; #1;
        end
        start = 1'b0;
        if (edges !== RUN_A) begin n_bad++; $display("FAIL b2b_second_len: got %0d want %0d", edges, RUN_A); end
        n_cmp++;
    endtask

    task automatic test_default_banks();
        int edges, base, raw, efch; bit efev;
        logic [7:0] efg, efd;
        base = $urandom_range(0, 255);
        raw = 0; efev = 0; efch = 0; efg = 8'h0; efd = 8'h0;
        for (int p = 0; p < PD; p++) begin
            for (int c = 0; c < ND; c++) begin
                if (bank_gold(base, p, c) != bank_dut(base, p, c)) begin
                    raw++;
                    if (!efev) begin efev = 1; efch = c; efg = bank_gold(base, p, c); efd = bank_dut(base, p, c); end
                end
            end
        end
        for (int c = 0; c < ND; c++) begin
            d_gold[c*8 +: 8] = bank_gold(base, 0, c); d_dut[c*8 +: 8] = bank_dut(base, 0, c);
        end
        @(posedge clk); #1 d_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        edges = 0;
        while (!d_done && edges < RUN_D + 200) begin
            @(posedge clk); edges++; #1;
            if (edges % (2 * ND) == 0 && edges / (2 * ND) < PD) begin
                for (int c = 0; c < ND; c++) begin
                    d_gold[c*8 +: 8] = bank_gold(base, edges / (2 * ND), c);
                    d_dut[c*8 +: 8]  = bank_dut(base, edges / (2 * ND), c);
                end
            end
        end
        if (edges !== RUN_D) begin n_bad++; $display("FAIL dflt_len: got %0d want %0d", edges, RUN_D); end
        n_cmp++;
        if ({d_pass, d_mm} !== {1'b0, 16'(raw)}) begin
            n_bad++; $display("FAIL dflt_result: pass %b mm %0d want 0/%0d", d_pass, d_mm, raw);
        end
        n_cmp++;
        if ({d_fev, d_fch, d_fg, d_fd} !== {efev, 4'(efch), efg, efd}) begin
            n_bad++; $display("FAIL dflt_first: got %h want %h", {d_fev, d_fch, d_fg, d_fd}, {efev, 4'(efch), efg, efd});
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_single_ch();
        test_saturate();
        test_random();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        test_default_banks();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnt_scan_checker.md
# cnt_scan_checker

Synthesizable on-chip counterpart of the multi-clock counter compare flow. It sits directly downstream of the multi-clock counter bank and consumes NUM_CH pairs of counter values: golden and device-under-test, both already resynchronized into the design_clk domain. A round-robin FSM scans the pairs and compares each one. It accumulates a saturating mismatch count, captures the first failing channel, and reports pass/fail after a programmed number of full scan passes.

## Interface
Parameters:
- NUM_CH, 16, number of channel pairs scanned
- CNT_W, 8, width of each counter value
- PASSES, 200, number of full scan passes per run (>=1)
- ERR_W, 16, width of the mismatch counter
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived)

Ports:
- design_clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  run request; sampled only in IDLE or DONE
- cnt_gold  in  NUM_CH*CNT_W  golden counters; channel k at bits [k*CNT_W +: CNT_W]
- cnt_dut  in  NUM_CH*CNT_W  DUT counters; same packing as cnt_gold
- busy  out  1  run in progress (CAPTURE/COMPARE)
- done  out  1  run finished; level, held in DONE
- pass  out  1  done && mismatch_cnt==0
- mismatch_cnt  out  ERR_W  saturating mismatch count
- first_err_valid  out  1  at least one mismatch captured this run
- first_err_ch  out  CH_W  channel of first mismatch
- first_err_gold  out  CNT_W  golden value at first mismatch
- first_err_dut  out  CNT_W  DUT value at first mismatch
- cur_ch  out  CH_W  channel currently being scanned

## Operation
- States: IDLE, CAPTURE, COMPARE, DONE. Reset value is IDLE.
- Reset value of all outputs and internal registers is 0, including busy, done, pass, counters and first_err_*.
- IDLE/DONE with start=1: go to CAPTURE.
  - Clear mismatch_cnt, first_err_*, pass, done and the pass counter.
  - Set cur_ch=0.
- CAPTURE: register cnt_gold[cur_ch] and cnt_dut[cur_ch] into sample registers (one registered mux stage), then go to COMPARE.
- COMPARE: if sample_gold != sample_dut:
  - mismatch_cnt += 1, saturating at 2^ERR_W-1.
  - If first_err_valid==0, load first_err_ch=cur_ch, first_err_gold, first_err_dut, and set first_err_valid=1.
- COMPARE advance:
  - If cur_ch==NUM_CH-1, wrap cur_ch to 0 and increment the pass counter.
  - If that completes pass PASSES, go to DONE; otherwise go to CAPTURE.
  - If cur_ch<NUM_CH-1, cur_ch+1 and go to CAPTURE.
- DONE: done=1 and busy=0. pass is registered as (mismatch_cnt==0), including the final compare. State holds until start or reset.
- start while busy=1 is ignored; no restart and no effect on statistics.
- Comparison is 2-state inequality over the full CNT_W bits.
- Inputs are sampled only in CAPTURE. Input changes during COMPARE do not affect the current result.
- first_err_* holds only the first mismatch of a run. Later mismatches do not overwrite it, even after mismatch_cnt saturates.
- Pass counter width is $clog2(PASSES+1).

## Timing
- Edge E0 samples start=1; busy rises after E0.
- Each channel takes 2 cycles: capture at E0+2k+1, compare result visible after E0+2k+2, for global scan index k.
- Run length: done and pass are valid after edge E0+2*NUM_CH*PASSES. busy falls on the same edge done rises.
- Defaults: 2*16*200 = 6400 cycles.
- mismatch_cnt and first_err_* update on the edge that ends COMPARE.
- Reset asserted mid-run forces IDLE immediately (asynchronous) and clears all outputs.
  - After deassertion the block stays in IDLE until a new start.
  - Statistics from the aborted run are lost.
- start held high continuously: a new run begins on the first edge in DONE.
  - done is visible for exactly one cycle, and the outputs of the completed run are cleared on that edge.

## Test plan
- NUM_CH=4, PASSES=3; cnt_gold==cnt_dut==8'h5A on all channels; pulse start -> done after 24 cycles, pass=1, mismatch_cnt=0, first_err_valid=0.
- Same config; channel 2 dut=8'h11, gold=8'h10 -> done after 24 cycles, pass=0, mismatch_cnt=3, first_err_ch=2, first_err_gold=8'h10, first_err_dut=8'h11.
- ERR_W=2, all 4 channels mismatched, PASSES=3 -> mismatch_cnt saturates at 3; first_err_ch=0.
- Assert reset at cycle 9 of a run -> busy=0, done=0, mismatch_cnt=0 immediately. After release and a new start, the full 24-cycle run completes normally.
- Pulse start again at cycle 5 while busy -> ignored; done still after edge E0+24.
- Defaults; drive cnt_gold/cnt_dut from two counter banks that diverge on channel 15 after 100 passes -> pass=0, first_err_ch=15, mismatch_cnt=100, done at E0+6400.
